// File: rtl/divisor_restauracion_pkg.sv
// rtl/divisor_restauracion_pkg.sv - shared FSM states and sizing for the restoring divider
package div_pkg;

  localparam int N_DEF = 3;
  localparam int CNT_W = $clog2(2 * N_DEF + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} estado_t;

  function automatic int cnt_ancho(input int n);
    return $clog2(2 * n + 1);
  endfunction

endpackage

// File: rtl/divisor_restauracion_if.sv
// rtl/divisor_restauracion_if.sv - request/result bundle between a requester and the divider
interface divisor_restauracion_if #(
  parameter int N = div_pkg::N_DEF
);
  logic           start;
  logic [2*N-1:0] dividendo;
  logic [N-1:0]   divisor;
  logic [2*N-1:0] cociente;
  logic [N-1:0]   resto;
  logic           ocupado;
  logic           Fin;
  logic           div_cero;

  modport master (output start, dividendo, divisor,
                  input  cociente, resto, ocupado, Fin, div_cero);
  modport slave  (input  start, dividendo, divisor,
                  output cociente, resto, ocupado, Fin, div_cero);
endinterface

// File: rtl/cd_divisor.sv
// rtl/cd_divisor.sv - restoring-divider datapath; DIV_SIGNO_EN adds sign latches and negators
module cd_divisor
  import div_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic           paso,
  input  logic           restaurar,
  input  logic           fijar,
  input  logic           fijar_cero,
  input  logic [2*N-1:0] dividendo,
  input  logic [N-1:0]   divisor,
  output logic           a_negativo,
  output logic           cnt_fin,
  output logic           es_cero,
  output logic [2*N-1:0] cociente,
  output logic [N-1:0]   resto,
  output logic           div_cero
);
  localparam int CW = cnt_ancho(N);
  localparam logic [CW-1:0] ULTIMO = CW'(2 * N - 1);

  logic [N-1:0]   a_q;
  logic [2*N-1:0] q_q;
  logic [N-1:0]   m_q;
  logic [CW-1:0]  cnt_q;
  logic           cero_q;
  logic [2*N-1:0] cociente_q;
  logic [N-1:0]   resto_q;
  logic           div_cero_q;

  logic [2*N-1:0] q_mag;
  logic [N-1:0]   m_mag;
  logic [2*N-1:0] cociente_fix;
  logic [N-1:0]   resto_fix;
  logic [N:0]     a_sh;
  logic [N:0]     prueba;

`ifdef DIV_SIGNO_EN
  logic sq_q, sr_q;

  // Magnitudes are plain unsigned values, so the most-negative operand still fits
  assign q_mag        = dividendo[2*N-1] ? (~dividendo + 1'b1) : dividendo;
  assign m_mag        = divisor[N-1] ? (~divisor + 1'b1) : divisor;
  assign cociente_fix = sq_q ? (~q_q + 1'b1) : q_q;
  assign resto_fix    = sr_q ? (~a_q + 1'b1) : a_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sq_q <= 1'b0;
      sr_q <= 1'b0;
    end else if (load) begin
      sq_q <= dividendo[2*N-1] ^ divisor[N-1];
      sr_q <= dividendo[2*N-1];
    end
  end
`else
  assign q_mag        = dividendo;
  assign m_mag        = divisor;
  assign cociente_fix = q_q;
  assign resto_fix    = a_q;
`endif

  // A stays below M after each restore, so N bits hold it; the trial needs N+1
  assign a_sh       = {a_q, q_q[2*N-1]};
  assign prueba     = a_sh - {1'b0, m_q};
  assign a_negativo = prueba[N];
  assign cnt_fin    = (cnt_q == ULTIMO);
  assign es_cero    = cero_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q    <= '0;
      q_q    <= '0;
      m_q    <= '0;
      cnt_q  <= '0;
      cero_q <= 1'b0;
    end else if (load) begin
      a_q    <= '0;
      q_q    <= q_mag;
      m_q    <= m_mag;
      cnt_q  <= '0;
      cero_q <= (divisor == '0);
    end else if (paso) begin
      cnt_q <= cnt_q + 1'b1;
      if (restaurar) begin
        a_q <= a_sh[N-1:0];
        q_q <= {q_q[2*N-2:0], 1'b0};
      end else begin
        a_q <= prueba[N-1:0];
        q_q <= {q_q[2*N-2:0], 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cociente_q <= '0;
      resto_q    <= '0;
      div_cero_q <= 1'b0;
    end else if (fijar) begin
      cociente_q <= cociente_fix;
      resto_q    <= resto_fix;
      div_cero_q <= 1'b0;
    end else if (fijar_cero) begin
      cociente_q <= '1;
      resto_q    <= '0;
      div_cero_q <= 1'b1;
    end
  end

  assign cociente = cociente_q;
  assign resto    = resto_q;
  assign div_cero = div_cero_q;
endmodule

// File: rtl/divisor_restauracion.sv
// rtl/divisor_restauracion.sv - restoring divider top: control FSM around cd_divisor (DIV_SIGNO_EN selects signed mode)
module divisor_restauracion
  import div_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  divisor_restauracion_if.slave bus
);
  estado_t state_q, state_d;
  logic    fin_q, fin_d;
  logic    load, paso, restaurar, fijar, fijar_cero;
  logic    a_negativo, cnt_fin, es_cero;
  logic    divisor_nulo;

  assign divisor_nulo = (bus.divisor == '0);
  assign restaurar    = paso & a_negativo;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fin_q   <= fin_d;
    end
  end

  // A normal DONE is the Fin cycle, so it accepts a new request like IDLE does
  always_comb begin
    state_d    = state_q;
    fin_d      = 1'b0;
    load       = 1'b0;
    paso       = 1'b0;
    fijar      = 1'b0;
    fijar_cero = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = divisor_nulo ? DONE : CALC;
        end
      end
      CALC: begin
        paso = 1'b1;
        if (cnt_fin) state_d = FIX;
      end
      FIX: begin
        fijar   = 1'b1;
        fin_d   = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (es_cero) begin
          fijar_cero = 1'b1;
          fin_d      = 1'b1;
          state_d    = IDLE;
        end else if (bus.start) begin
          load    = 1'b1;
          state_d = divisor_nulo ? DONE : CALC;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ocupado = (state_q == CALC) || (state_q == FIX) || ((state_q == DONE) && es_cero);
  assign bus.Fin     = fin_q;

  cd_divisor #(.N(N)) u_cd (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .paso       (paso),
    .restaurar  (restaurar),
    .fijar      (fijar),
    .fijar_cero (fijar_cero),
    .dividendo  (bus.dividendo),
    .divisor    (bus.divisor),
    .a_negativo (a_negativo),
    .cnt_fin    (cnt_fin),
    .es_cero    (es_cero),
    .cociente   (bus.cociente),
    .resto      (bus.resto),
    .div_cero   (bus.div_cero)
  );
endmodule
